// File: rtl/bram_uart_streamer.sv
// BRAM-to-UART word streamer: reads a range of BRAM words, splits them into bytes and sends them 8N1.
// Define STREAM_CHECKSUM_EN to append a mod-256 checksum byte to every frame.
module bram_uart_streamer #(
   parameter int BRAM_LENGTH     = 1000,
   parameter int BIT_DEPTH       = 24,
   parameter int BRAM_LATENCY    = 2,
   parameter int CLOCKS_PER_BAUD = 50,
   parameter bit MSB_FIRST       = 1'b1,
   localparam int AW             = $clog2(BRAM_LENGTH)
) (
   input  logic                 clk,
   input  logic                 rst_in,
   input  logic                 start,
   input  logic [AW-1:0]        base_addr,
   input  logic [AW:0]          word_count,
   input  logic [BIT_DEPTH-1:0] data,
   output logic [AW-1:0]        address,
   output logic                 tx,
   output logic                 busy,
   output logic                 done,
   output logic [15:0]          bytes_sent
);
   localparam int NB = BIT_DEPTH / 8;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam int CW = $clog2(CLOCKS_PER_BAUD);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, FINISH} state_t;

   state_t               state, state_next;
   logic [AW-1:0]        addr;
   logic [AW:0]          words_left;
   logic [2:0]           lat_cnt;
   logic [CW-1:0]        baud_cnt;
   logic [3:0]           bit_idx;
   logic [BW-1:0]        byte_idx;
   logic [BIT_DEPTH-1:0] word_reg;
   logic [7:0]           cur_byte;
   logic                 fetch_done, baud_end, byte_end, last_byte, last_word, data_phase, tx_bit;
   logic [7:0]           load_byte, next_byte;
   logic [BIT_DEPTH-1:0] load_rest, next_rest;
`ifdef STREAM_CHECKSUM_EN
   logic [7:0]           csum;
   logic                 csum_phase;
   assign data_phase = !csum_phase;
`else
   assign data_phase = 1'b1;
`endif

   assign fetch_done = (lat_cnt == 3'(BRAM_LATENCY - 1));
   assign baud_end   = (baud_cnt == CW'(CLOCKS_PER_BAUD - 1));
   assign byte_end   = baud_end && (bit_idx == 4'd9);
   assign last_byte  = (byte_idx == BW'(NB - 1));
   assign last_word  = (words_left == (AW+1)'(1));
   assign address    = addr;
   assign done       = (state == FINISH);

   // Byte extraction: the word register is consumed from whichever end goes first.
   always_comb begin
      if (MSB_FIRST) begin
         load_byte = data[BIT_DEPTH-1 -: 8];
         load_rest = data << 8;
         next_byte = word_reg[BIT_DEPTH-1 -: 8];
         next_rest = word_reg << 8;
      end else begin
         load_byte = data[7:0];
         load_rest = data >> 8;
         next_byte = word_reg[7:0];
         next_rest = word_reg >> 8;
      end
      // Frame: start bit, 8 data bits taken from cur_byte[0] as it shifts, stop bit.
      tx_bit = (bit_idx == 4'd0) ? 1'b0 : (bit_idx == 4'd9) ? 1'b1 : cur_byte[0];
   end

   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:
            if (start) begin
               if (word_count != '0) state_next = FETCH;
               else
`ifdef STREAM_CHECKSUM_EN
                  state_next = SEND;
`else
                  state_next = FINISH;
`endif
            end
         FETCH:  if (fetch_done) state_next = LOAD;
         LOAD:   state_next = SEND;
         SEND:
            if (byte_end) begin
               if (!data_phase)                 state_next = FINISH;
               else if (last_byte && !last_word) state_next = FETCH;
`ifndef STREAM_CHECKSUM_EN
               else if (last_byte)              state_next = FINISH;
`endif
            end
         FINISH: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: tx is registered so it is glitch-free and forced high the instant reset asserts.
   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         tx         <= 1'b1;
         busy       <= 1'b0;
         bytes_sent <= '0;
         addr       <= '0;
         words_left <= '0;
         lat_cnt    <= '0;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         byte_idx   <= '0;
         word_reg   <= '0;
         cur_byte   <= '0;
`ifdef STREAM_CHECKSUM_EN
         csum       <= '0;
         csum_phase <= 1'b0;
`endif
      end else begin
         tx <= 1'b1;
         case (state)
            IDLE:
               if (start) begin
                  addr       <= base_addr;
                  words_left <= word_count;
                  busy       <= 1'b1;
                  bytes_sent <= '0;
                  lat_cnt    <= '0;
                  baud_cnt   <= '0;
                  bit_idx    <= '0;
                  cur_byte   <= '0;
`ifdef STREAM_CHECKSUM_EN
                  csum       <= '0;
                  csum_phase <= (word_count == '0);
`endif
               end
            FETCH: lat_cnt <= lat_cnt + 3'd1;
            LOAD: begin
               word_reg <= load_rest;
               cur_byte <= load_byte;
               byte_idx <= '0;
               lat_cnt  <= '0;
               baud_cnt <= '0;
               bit_idx  <= '0;
`ifdef STREAM_CHECKSUM_EN
               csum     <= csum + load_byte;
`endif
            end
            SEND: begin
               tx <= tx_bit;
               if (!baud_end) begin
                  baud_cnt <= baud_cnt + 1'b1;
               end else begin
                  baud_cnt <= '0;
                  bit_idx  <= bit_idx + 4'd1;
                  if (bit_idx >= 4'd1 && bit_idx <= 4'd8) cur_byte <= cur_byte >> 1;
                  if (bit_idx == 4'd9) begin
                     bit_idx <= '0;
                     if (bytes_sent != 16'hFFFF) bytes_sent <= bytes_sent + 16'd1;
                     if (data_phase) begin
                        if (!last_byte) begin
                           byte_idx <= byte_idx + 1'b1;
                           cur_byte <= next_byte;
                           word_reg <= next_rest;
`ifdef STREAM_CHECKSUM_EN
                           csum     <= csum + next_byte;
`endif
                        end else if (!last_word) begin
                           addr       <= (addr == AW'(BRAM_LENGTH - 1)) ? '0 : addr + 1'b1;
                           words_left <= words_left - 1'b1;
                        end
`ifdef STREAM_CHECKSUM_EN
                        else begin
                           cur_byte   <= csum;
                           csum_phase <= 1'b1;
                        end
`endif
                     end
                  end
               end
            end
            FINISH: busy <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_bram_uart_streamer.sv
// Self-checking bench: two streamers (MSB-first and LSB-first) against a waveform-level UART model.
module tb_bram_uart_streamer;
   localparam int BL = 1000, BD = 24, LAT = 2, CPB = 4, NB = 3, AW = 10;
`ifdef STREAM_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic clk = 1'b0;
   logic rst_in = 1'b0, start_a = 1'b0, start_b = 1'b0, sel = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   word_count = '0;
   logic [BD-1:0] data_a, data_b, pa, pb;
   logic [AW-1:0] addr_a, addr_b, m_addr;
   logic tx_a, tx_b, busy_a, busy_b, done_a, done_b, m_tx, m_busy, m_done;
   logic [15:0] bs_a, bs_b, m_bs;
   logic [BD-1:0] mem [BL];

   int n_pass = 0, n_total = 0;
   bit exp_wave[$];
   int exp_addr[$];
   int exp_done_idx;

   always #5 clk = ~clk;

   // Synchronous-read BRAM model with two cycles of latency per instance.
   always @(posedge clk) begin
      pa <= mem[addr_a]; data_a <= pa;
      pb <= mem[addr_b]; data_b <= pb;
   end

   always_comb begin
      m_tx   = sel ? tx_b   : tx_a;
      m_busy = sel ? busy_b : busy_a;
      m_done = sel ? done_b : done_a;
      m_addr = sel ? addr_b : addr_a;
      m_bs   = sel ? bs_b   : bs_a;
   end

   bram_uart_streamer #(.BRAM_LENGTH(BL), .BIT_DEPTH(BD), .BRAM_LATENCY(LAT),
                        .CLOCKS_PER_BAUD(CPB), .MSB_FIRST(1'b1)) dut_a (
      .clk(clk), .rst_in(rst_in), .start(start_a), .base_addr(base_addr), .word_count(word_count),
      .data(data_a), .address(addr_a), .tx(tx_a), .busy(busy_a), .done(done_a), .bytes_sent(bs_a));

   bram_uart_streamer #(.BRAM_LENGTH(BL), .BIT_DEPTH(BD), .BRAM_LATENCY(LAT),
                        .CLOCKS_PER_BAUD(CPB), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst_in(rst_in), .start(start_b), .base_addr(base_addr), .word_count(word_count),
      .data(data_b), .address(addr_b), .tx(tx_b), .busy(busy_b), .done(done_b), .bytes_sent(bs_b));

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   // Expected tx level for every cycle after the accepting edge, built from the framing rules.
   task automatic build_expect(input bit lsb, input int base, input int wc);
      int a = base, sum = 0;
      int bytes[$];
      exp_wave.delete(); exp_addr.delete();
      exp_addr.push_back(base);
      for (int w = 0; w < wc; w++) begin
         if (w > 0) begin a = (a + 1) % BL; exp_addr.push_back(a); end
         for (int k = 0; k < NB; k++) begin
            int sh = lsb ? 8 * k : 8 * (NB - 1 - k);
            int b = (int'(mem[a]) >> sh) & 255;
            bytes.push_back(b);
            sum = (sum + b) % 256;
         end
      end
      if (CS == 1) bytes.push_back(sum);
      repeat ((wc == 0) ? 1 : LAT + 2) exp_wave.push_back(1'b1);
      for (int j = 0; j < bytes.size(); j++) begin
         if (j > 0 && j % NB == 0 && j < wc * NB) repeat (LAT + 1) exp_wave.push_back(1'b1);
         for (int bit_n = 0; bit_n < 10; bit_n++) begin
            bit lvl = (bit_n == 0) ? 1'b0 : (bit_n == 9) ? 1'b1 : 1'(bytes[j] >> (bit_n - 1));
            repeat (CPB) exp_wave.push_back(lvl);
         end
      end
      exp_done_idx = (bytes.size() == 0) ? 0 : exp_wave.size() - 1;
   endtask

   task automatic run_frame(input string tag, input bit lsb, input int base, input int wc,
                            input bit inject, input int exp_bs);
      int tx_bad = -1, busy_bad = -1, done_at = -1, done_cnt = 0, addr_err = 0;
      int got_addr[$];
      build_expect(lsb, base, wc);
      @(posedge clk); #1;
      sel = lsb; base_addr = AW'(base); word_count = (AW+1)'(wc);
      if (lsb) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
      for (int idx = 0; idx <= exp_done_idx + 1; idx++) begin
         if (idx > 0) begin @(posedge clk); #1; end
         if (inject && idx == 51) begin start_a = 1'b0; start_b = 1'b0; end
         if (m_tx !== ((idx < exp_wave.size()) ? exp_wave[idx] : 1'b1) && tx_bad < 0) tx_bad = idx;
         if (m_busy !== (idx <= exp_done_idx) && busy_bad < 0) busy_bad = idx;
         if (m_done === 1'b1) begin done_cnt++; if (done_at < 0) done_at = idx; end
         if (got_addr.size() == 0 || got_addr[$] != int'(m_addr)) got_addr.push_back(int'(m_addr));
         if (inject && idx == 50) begin
            base_addr = '0; word_count = 5;
            if (lsb) start_b = 1'b1; else start_a = 1'b1;
         end
      end
      start_a = 1'b0; start_b = 1'b0;
      if (got_addr.size() != exp_addr.size()) addr_err = 1000;
      else foreach (exp_addr[i]) if (got_addr[i] != exp_addr[i]) addr_err++;
      check({tag, " tx_wave first bad cycle"}, tx_bad, -1);
      check({tag, " busy first bad cycle"}, busy_bad, -1);
      check({tag, " done cycle"}, done_at, exp_done_idx);
      check({tag, " done pulses"}, done_cnt, 1);
      check({tag, " bytes_sent"}, int'(m_bs), exp_bs);
      check({tag, " address seq errors"}, addr_err, 0);
   endtask

   typedef struct {
      bit            lsb;
      int            base;
      int            wc;
      logic [BD-1:0] w0;
      bit            inject;
      int            exp_bs;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{1'b0, 5,   1, 24'hA1B2C3, 1'b1, 3 + CS};
      vecs[1] = '{1'b1, 998, 3, 24'h112233, 1'b0, 9 + CS};
      vecs[2] = '{1'b0, 999, 2, 24'h00FF80, 1'b0, 6 + CS};
      vecs[3] = '{1'b1, 0,   0, 24'h000000, 1'b0, CS};
      vecs[4] = '{1'b1, 10,  4, 24'hFFFFFF, 1'b0, 12 + CS};
      for (int i = 0; i < BL; i++) mem[i] = BD'($urandom);

      // Reset with no clock edges yet.
      #1 rst_in = 1'b1;
      #1;
      check("reset tx", int'(tx_a), 1);
      check("reset busy", int'(busy_a), 0);
      check("reset done", int'(done_a), 0);
      check("reset address", int'(addr_a), 0);
      check("reset bytes_sent", int'(bs_a), 0);
      #1 rst_in = 1'b0;

      foreach (vecs[i]) begin
         mem[vecs[i].base] = vecs[i].w0;
         run_frame($sformatf("vec%0d", i), vecs[i].lsb, vecs[i].base, vecs[i].wc,
                   vecs[i].inject, vecs[i].exp_bs);
      end

      // Reset during the data bits of the second byte, then a clean rerun.
      mem[5] = 24'hA1B2C3;
      @(posedge clk); #1;
      base_addr = 5; word_count = 1; start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      check("mid bytes_sent before reset", int'(bs_a), 1);
      rst_in = 1'b1;
      #1;
      check("mid reset tx", int'(tx_a), 1);
      check("mid reset busy", int'(busy_a), 0);
      check("mid reset address", int'(addr_a), 0);
      check("mid reset bytes_sent", int'(bs_a), 0);
      #1 rst_in = 1'b0;
      run_frame("after_reset", 1'b0, 5, 1, 1'b0, 3 + CS);

      for (int r = 0; r < 6; r++) begin
         int wc = $urandom_range(1, 3);
         run_frame($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), $urandom_range(0, BL - 1),
                   wc, 1'b0, wc * NB + CS);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
